// File: rtl/sample_print_scheduler.sv
// Periodic print scheduler: latches the newest sample and hands it to the
// ASCII converter/printer once per period. Option: SCHED_REPEAT_LAST_EN.
module sample_print_scheduler #(
  parameter int PERIOD_CYCLES = 100_000_000,
  parameter int CONV_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [13:0] sample_X,
  input  logic [13:0] sample_Y,
  input  logic [13:0] sample_Z,
  input  logic [19:0] sample_T,
  input  logic        print_busy,
  output logic [13:0] bin_X,
  output logic [13:0] bin_Y,
  output logic [13:0] bin_Z,
  output logic [19:0] bin_T,
  output logic        data_ready_for_printing,
  output logic        sched_busy,
  output logic [7:0]  skip_count
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [3:0] CONV_LAST = 4'(CONV_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, CONVERT, PRINT_REQ, WAIT_PRINT
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] period_cnt;
  logic tick;
  logic held_valid;
  logic [61:0] hold;
  logic [61:0] bin_all;
  logic [3:0] conv_cnt;
  logic wait_first;
  logic start_ok;

  assign tick = (period_cnt == LAST);
  assign sched_busy = (state != IDLE);
  assign {bin_X, bin_Y, bin_Z, bin_T} = bin_all;

`ifdef SCHED_REPEAT_LAST_EN
  // Remembers that bin_* hold a real sample worth reprinting.
  logic loaded_once;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      loaded_once <= 1'b0;
    else if (state == LOAD)
      loaded_once <= 1'b1;
  end

  assign start_ok = held_valid | loaded_once;
`else
  assign start_ok = held_valid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      period_cnt <= '0;
    else if (tick)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid <= 1'b0;
      hold       <= '0;
    end else if (sample_valid) begin
      held_valid <= 1'b1;
      hold       <= {sample_X, sample_Y, sample_Z, sample_T};
    end else if (state == LOAD) begin
      held_valid <= 1'b0;
    end
  end

  // Without a fresh sample in LOAD the old bin_* are reprinted as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bin_all <= '0;
    else if (state == LOAD && held_valid)
      bin_all <= hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      skip_count <= '0;
    else if (tick && state != IDLE && skip_count != 8'hFF)
      skip_count <= skip_count + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      conv_cnt   <= '0;
      wait_first <= 1'b0;
    end else begin
      state      <= state_nx;
      conv_cnt   <= (state == CONVERT) ? conv_cnt + 4'd1 : 4'd0;
      wait_first <= (state == PRINT_REQ);
    end
  end

  always_comb begin
    state_nx = state;
    data_ready_for_printing = 1'b0;
    unique case (state)
      IDLE:
        if (tick && start_ok)
          state_nx = LOAD;
      LOAD:
        state_nx = CONVERT;
      CONVERT:
        if (conv_cnt == CONV_LAST)
          state_nx = PRINT_REQ;
      PRINT_REQ:
        if (!print_busy) begin
          data_ready_for_printing = 1'b1;
          state_nx = WAIT_PRINT;
        end
      WAIT_PRINT:
        if (!wait_first && !print_busy)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_print_scheduler.sv
// Bench for sample_print_scheduler: directed and random scenarios compared
// against an event-level model built from period/latency rules.
module tb_sample_print_scheduler;

  localparam int P  = 10;
  localparam int CL = 2;
  localparam int N  = 700;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [13:0] sample_X = '0;
  logic [13:0] sample_Y = '0;
  logic [13:0] sample_Z = '0;
  logic [19:0] sample_T = '0;
  logic        print_busy = 1'b0;
  logic [13:0] bin_X, bin_Y, bin_Z;
  logic [19:0] bin_T;
  logic        data_ready_for_printing;
  logic        sched_busy;
  logic [7:0]  skip_count;

  sample_print_scheduler #(
    .PERIOD_CYCLES(P),
    .CONV_LATENCY(CL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample_X(sample_X),
    .sample_Y(sample_Y),
    .sample_Z(sample_Z),
    .sample_T(sample_T),
    .print_busy(print_busy),
    .bin_X(bin_X),
    .bin_Y(bin_Y),
    .bin_Z(bin_Z),
    .bin_T(bin_T),
    .data_ready_for_printing(data_ready_for_printing),
    .sched_busy(sched_busy),
    .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  bit          a_sv   [N];
  logic [61:0] a_val  [N];
  bit          a_busy [N];
  bit          e_req  [N];
  logic [61:0] e_bin  [N];
  int          e_skip [N];
  bit          e_busy [N];
  bit          o_req  [N];
  logic [61:0] o_bin  [N];
  int          o_skip [N];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      a_sv[i] = 1'b0;
      a_val[i] = '0;
      a_busy[i] = 1'b0;
    end
  endtask

  // Each accepted tick t: LOAD at t+1, request at first idle-printer
  // cycle >= t+CL+2, back in IDLE after the wait phase completes.
  task automatic compute_model(input int len);
    int idle_from, seq_start, last_load, last_sc, pend, skip, r, d;
    bit loaded, held, go;
    logic [61:0] cur, last_val;
    idle_from = 0; seq_start = -1; last_load = 0; last_sc = -1;
    pend = -1; skip = 0; loaded = 0; cur = '0; last_val = '0;
    for (int c = 0; c < N; c++) e_req[c] = 1'b0;
    for (int c = 0; c < len; c++) begin
      e_bin[c]  = cur;
      e_skip[c] = skip;
      e_busy[c] = (c > seq_start) && (c < idle_from);
      if (c == pend) begin
        if (last_sc >= last_load) cur = last_val;
        last_load = c;
        loaded = 1'b1;
      end
      if (c % P == P - 1) begin
        if (c < idle_from) begin
          if (skip < 255) skip++;
        end else begin
          held = (last_sc >= last_load);
`ifdef SCHED_REPEAT_LAST_EN
          go = held || loaded;
`else
          go = held;
`endif
          if (go) begin
            seq_start = c;
            pend = c + 1;
            r = c + CL + 2;
            while (r < len && a_busy[r]) r++;
            if (r < len) e_req[r] = 1'b1;
            d = r + 2;
            while (d < len && a_busy[d]) d++;
            idle_from = d + 1;
          end
        end
      end
      if (a_sv[c]) begin
        last_sc = c;
        last_val = a_val[c];
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    print_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bin", 64'({bin_X, bin_Y, bin_Z, bin_T}), 64'd0);
    check("rst_req", 64'(data_ready_for_printing), 64'd0);
    check("rst_skip", 64'(skip_count), 64'd0);
    check("rst_busy", 64'(sched_busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input string tag, input int len);
    compute_model(len);
    do_reset();
    for (int c = 0; c < len; c++) begin
      sample_valid = a_sv[c];
      {sample_X, sample_Y, sample_Z, sample_T} = a_val[c];
      print_busy = a_busy[c];
      @(negedge clk);
      o_req[c]  = data_ready_for_printing;
      o_bin[c]  = {bin_X, bin_Y, bin_Z, bin_T};
      o_skip[c] = int'(skip_count);
      check($sformatf("%s_req@%0d", tag, c),
            64'(data_ready_for_printing), 64'(e_req[c]));
      check($sformatf("%s_bin@%0d", tag, c),
            64'({bin_X, bin_Y, bin_Z, bin_T}), 64'(e_bin[c]));
      check($sformatf("%s_skip@%0d", tag, c),
            64'(skip_count), 64'(e_skip[c]));
      check($sformatf("%s_busy@%0d", tag, c),
            64'(sched_busy), 64'(e_busy[c]));
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    print_busy = 1'b0;
  endtask

  function automatic int count_req(input int len);
    int n = 0;
    for (int c = 0; c < len; c++) n += int'(o_req[c]);
    return n;
  endfunction

  initial begin
    bit bz;
    // Basic print path, exact cycle positions
    clear_stim();
    a_sv[3] = 1'b1; a_val[3] = {14'h0621, 14'h0, 14'h0, 20'h0};
    run("basic", 20);
    check("basic_binx11", 64'(o_bin[11][61:48]), 64'h0621);
    check("basic_binx10", 64'(o_bin[10][61:48]), 64'h0);
    check("basic_req13", 64'(o_req[13]), 64'd1);
    check("basic_nreq", 64'(count_req(20)), 64'd1);

    // Printer busy for 20 cycles from the tick
    clear_stim();
    a_sv[3] = 1'b1; a_val[3] = {14'h0123, 14'h1, 14'h2, 20'h3};
    for (int c = 9; c < 29; c++) a_busy[c] = 1'b1;
    run("busy", 45);
    check("busy_req29", 64'(o_req[29]), 64'd1);
    check("busy_nreq", 64'(count_req(45)), 64'd1);
    check("busy_skip20", 64'(o_skip[20]), 64'd1);
    check("busy_skip35", 64'(o_skip[35]), 64'd2);

    // Newer sample overwrites older one
    clear_stim();
    a_sv[2] = 1'b1; a_val[2] = {14'h0005, 14'h0, 14'h0, 20'h0};
    a_sv[5] = 1'b1; a_val[5] = {14'h3FFB, 14'h0, 14'h0, 20'h0};
    run("ovr", 20);
    check("ovr_binx", 64'(o_bin[15][61:48]), 64'h3FFB);
    check("ovr_nreq", 64'(count_req(20)), 64'd1);

    // Sample arriving in the LOAD cycle
    clear_stim();
    a_sv[2] = 1'b1; a_val[2] = {14'h0003, 14'h0, 14'h0, 20'h0};
    a_sv[10] = 1'b1; a_val[10] = {14'h0007, 14'h0, 14'h0, 20'h0};
    run("ldcap", 30);
    check("ldcap_old", 64'(o_bin[15][61:48]), 64'h3);
    check("ldcap_new", 64'(o_bin[25][61:48]), 64'h7);
    check("ldcap_nreq", 64'(count_req(30)), 64'd2);

    // Idle periods after a single print
    clear_stim();
    a_sv[3] = 1'b1; a_val[3] = {14'h0011, 14'h22, 14'h33, 20'h44};
    run("idle", 45);
`ifdef SCHED_REPEAT_LAST_EN
    check("idle_nreq", 64'(count_req(45)), 64'd4);
`else
    check("idle_nreq", 64'(count_req(45)), 64'd1);
`endif
    check("idle_skip", 64'(o_skip[44]), 64'd0);
    check("idle_bin", 64'(o_bin[44]), 64'({14'h11, 14'h22, 14'h33, 20'h44}));

    // Randomized samples and printer busy bursts
    clear_stim();
    bz = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (bz) bz = ($urandom_range(5) != 0);
      else    bz = ($urandom_range(14) == 0);
      a_busy[c] = bz;
      a_sv[c] = ($urandom_range(5) == 0);
      a_val[c] = {$urandom, $urandom};
    end
    run("rand", 600);

    // Reset asserted during CONVERT aborts the sequence
    do_reset();
    for (int c = 0; c < 11; c++) begin
      sample_valid = (c == 3);
      sample_X = 14'h0621;
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    check("abort_inconv", 64'(sched_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_bin", 64'({bin_X, bin_Y, bin_Z, bin_T}), 64'd0);
    check("abort_req", 64'(data_ready_for_printing), 64'd0);
    check("abort_busy", 64'(sched_busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    begin
      int nreq = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        nreq += int'(data_ready_for_printing);
        @(posedge clk);
        #1;
      end
      check("abort_nreq", 64'(nreq), 64'd0);
      check("abort_skip", 64'(skip_count), 64'd0);
    end

    // Saturation of skip_count with a stuck printer
    do_reset();
    sample_valid = 1'b1;
    sample_X = 14'h0042;
    print_busy = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (3010) @(posedge clk);
    @(negedge clk);
    check("sat_skip", 64'(skip_count), 64'd255);
    check("sat_busy", 64'(sched_busy), 64'd1);
    print_busy = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sat_hold", 64'(skip_count), 64'd255);
    check("sat_idle", 64'(sched_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
